// File: rtl/aurora_tx_pkg.sv
// Shared types and constants for the Aurora 64b66b TX frame scheduler.
package aurora_tx_pkg;

    localparam int unsigned LANES    = 4;
    localparam int unsigned WORD_W   = 64;
    localparam int unsigned HDR_W    = 2;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STARVE_W = 8;

    localparam logic [HDR_W-1:0]  HDR_DATA  = 2'b01;
    localparam logic [HDR_W-1:0]  HDR_CTRL  = 2'b10;

    // Block-type 0x78 control blocks; the second byte distinguishes CC from idle.
    localparam logic [WORD_W-1:0] CC_WORD   = 64'h7880_0000_0000_0000;
    localparam logic [WORD_W-1:0] IDLE_WORD = 64'h7810_0000_0000_0000;

    typedef logic [LANES-1:0][WORD_W-1:0] tx_frame_t;
    typedef logic [LANES-1:0][HDR_W-1:0]  tx_hdr_t;

    typedef struct packed {
        tx_frame_t frame;
        tx_hdr_t   hdr;
    } tx_beat_t;

    typedef enum logic [1:0] {
        NOT_READY = 2'd0,
        RUN       = 2'd1,
        CC_SEQ    = 2'd2
    } tx_sched_state_t;

endpackage

// File: rtl/aurora_tx_frame_scheduler_cc_timer.sv
// Free-running clock-compensation interval timer with a sticky request flag.
module aurora_cc_timer
    import aurora_tx_pkg::*;
#(
    parameter int unsigned CC_PERIOD = 5000
)(
    input  logic Clk,
    input  logic Rst,
    input  logic Enable,
    input  logic Clear,
    output logic Pending
);

    localparam int unsigned TIMER_W = $clog2(CC_PERIOD);

    logic [TIMER_W-1:0] cc_timer;
    logic               pending_q;
    logic               expire;

    assign expire  = Enable && (cc_timer == TIMER_W'(CC_PERIOD - 1));
    // Expiry is visible in its own cycle so a coincident slot goes to CC.
    assign Pending = pending_q | expire;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cc_timer  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (Enable) begin
                cc_timer <= expire ? '0 : cc_timer + TIMER_W'(1);
            end
            pending_q <= (pending_q | expire) & ~Clear;
        end
    end

endmodule

// File: rtl/aurora_tx_frame_scheduler.sv
// Per-slot arbiter between CC sequences, user-K blocks, event data and idles.
module aurora_tx_frame_scheduler
    import aurora_tx_pkg::*;
#(
    parameter int unsigned CC_PERIOD      = 5000,
    parameter int unsigned CC_LEN         = 3,
    parameter int unsigned USERK_MAX_WAIT = 4
)(
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic                               LaneReady,
    input  logic                               TxReady,
    input  logic                               DataValid,
    input  logic [LANES-1:0][WORD_W-1:0]       DataWord,
    output logic                               DataRead,
    input  logic                               SendBlock,
    input  logic [LANES-1:0][WORD_W-1:0]       UserKToSend,
    output logic                               BlockSent,
    output logic [LANES-1:0][WORD_W-1:0]       TxFrame,
    output logic [LANES-1:0][HDR_W-1:0]        TxHeader,
    output logic                               TxValid
);

    tx_sched_state_t       state;
    logic [CNT_W-1:0]      cc_cnt;
    logic [STARVE_W-1:0]   starve_cnt;
    tx_beat_t              beat_q;
    tx_beat_t              beat_c;

    logic cc_pending;
    logic timer_rst;
    logic slot;
    logic uk_pend;
    logic sel_cc;
    logic sel_uk;
    logic sel_data;

    assign timer_rst = Rst | ~LaneReady;

    aurora_cc_timer #(
        .CC_PERIOD (CC_PERIOD)
    ) u_cc_timer (
        .Clk     (Clk),
        .Rst     (timer_rst),
        .Enable  (state != NOT_READY),
        .Clear   (sel_cc && (state == RUN)),
        .Pending (cc_pending)
    );

    // The user-K FSM drops SendBlock one cycle after BlockSent; mask that cycle.
    assign uk_pend  = SendBlock & ~BlockSent;
    assign slot     = TxReady & LaneReady & ~Rst & (state != NOT_READY);
    assign sel_cc   = slot & (cc_pending | (state == CC_SEQ));
    assign sel_uk   = slot & ~sel_cc & uk_pend &
                      (~DataValid | (starve_cnt == STARVE_W'(USERK_MAX_WAIT)));
    assign sel_data = slot & ~sel_cc & ~sel_uk & DataValid;
    assign DataRead = sel_data;

    // Frame/header selection for the current slot.
    always_comb begin
        beat_c.frame = {LANES{IDLE_WORD}};
        beat_c.hdr   = {LANES{HDR_CTRL}};
        if (sel_cc) begin
            beat_c.frame = {LANES{CC_WORD}};
        end else if (sel_uk) begin
            beat_c.frame = UserKToSend;
        end else if (sel_data) begin
            beat_c.frame = DataWord;
            beat_c.hdr   = {LANES{HDR_DATA}};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || !LaneReady) begin
            state      <= NOT_READY;
            cc_cnt     <= '0;
            starve_cnt <= '0;
            beat_q     <= '0;
            TxValid    <= 1'b0;
            BlockSent  <= 1'b0;
        end else begin
            TxValid   <= slot;
            BlockSent <= sel_uk;
            if (slot) begin
                beat_q <= beat_c;
            end

            if (state == NOT_READY) begin
                state <= RUN;
            end else if (sel_cc) begin
                if (cc_cnt == CNT_W'(CC_LEN - 1)) begin
                    state  <= RUN;
                    cc_cnt <= '0;
                end else begin
                    state  <= CC_SEQ;
                    cc_cnt <= cc_cnt + CNT_W'(1);
                end
            end

            if (!uk_pend || sel_uk) begin
                starve_cnt <= '0;
            end else if (sel_data && (starve_cnt != STARVE_W'(USERK_MAX_WAIT))) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

    assign TxFrame  = beat_q.frame;
    assign TxHeader = beat_q.hdr;

endmodule
